// File: rtl/gb_arb_pkg.sv
// Shared types and constants for the ghostbus host arbiter.
// Holds the FSM state encoding, the latency counter width and the read latency range check.
package gb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } arb_state_t;

    localparam int LAT_W = 4;

    function automatic bit rd_lat_ok(input int lat);
        return (lat >= 1) && (lat <= 15);
    endfunction

endpackage

// File: rtl/gb_host_arb_if.sv
// Bundle of both requester handshakes plus the ghostbus host port.
// The slave modport is the arbiter's view; the master modport is the requesters' and bus side.
interface gb_host_arb_if #(
    parameter int AW = 24,
    parameter int DW = 32
);
    logic          req0;
    logic          we0;
    logic [AW-1:0] addr0;
    logic [DW-1:0] wdata0;
    logic          ack0;
    logic [DW-1:0] rdata0;

    logic          req1;
    logic          we1;
    logic [AW-1:0] addr1;
    logic [DW-1:0] wdata1;
    logic          ack1;
    logic [DW-1:0] rdata1;

    logic [AW-1:0] gb_addr;
    logic [DW-1:0] gb_dout;
    logic          gb_we;
    logic          gb_re;
    logic [DW-1:0] gb_din;

    modport slave (
        input  req0, we0, addr0, wdata0,
        input  req1, we1, addr1, wdata1,
        input  gb_din,
        output ack0, rdata0, ack1, rdata1,
        output gb_addr, gb_dout, gb_we, gb_re
    );

    modport master (
        output req0, we0, addr0, wdata0,
        output req1, we1, addr1, wdata1,
        output gb_din,
        input  ack0, rdata0, ack1, rdata1,
        input  gb_addr, gb_dout, gb_we, gb_re
    );
endinterface

// File: rtl/gb_host_arb_rr_pick2.sv
// Combinational two-way round-robin picker.
// On a tie the requester that did not win last time is chosen.
module gb_rr_pick2 (
    input  logic req0,
    input  logic req1,
    input  logic last_grant,
    output logic grant_valid,
    output logic grant_idx
);

    always_comb begin
        grant_valid = req0 | req1;
        grant_idx   = req1;
        if (req0 && req1) begin
            grant_idx = ~last_grant;
        end
    end

endmodule

// File: rtl/gb_host_arb.sv
// Shares one ghostbus host port between two requesters, one transaction at a time,
// with single-cycle strobes and a fixed read latency before the read data is returned.
module gb_host_arb
    import gb_arb_pkg::*;
#(
    parameter int AW     = 24,
    parameter int DW     = 32,
    parameter int RD_LAT = 1
) (
    input logic        clk,
    input logic        rst_n,
    gb_host_arb_if.slave bus
);

    if (!rd_lat_ok(RD_LAT)) begin : g_rd_lat_range
        $error("gb_host_arb: RD_LAT %0d outside 1..15", RD_LAT);
    end

    arb_state_t       state;
    logic [LAT_W-1:0] lat_cnt;
    logic             last_grant;
    logic             gnt;
    logic             cur_we;

    logic             grant_valid;
    logic             grant_idx;
    logic             sel_we;
    logic [AW-1:0]    sel_addr;
    logic [DW-1:0]    sel_wdata;

    gb_rr_pick2 u_pick (
        .req0        (bus.req0),
        .req1        (bus.req1),
        .last_grant  (last_grant),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    always_comb begin
        sel_we    = grant_idx ? bus.we1    : bus.we0;
        sel_addr  = grant_idx ? bus.addr1  : bus.addr0;
        sel_wdata = grant_idx ? bus.wdata1 : bus.wdata0;
    end

    // Strobes and acks are single-cycle pulses; they default low every cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            lat_cnt     <= '0;
            last_grant  <= 1'b1;
            gnt         <= 1'b0;
            cur_we      <= 1'b0;
            bus.gb_addr <= '0;
            bus.gb_dout <= '0;
            bus.gb_we   <= 1'b0;
            bus.gb_re   <= 1'b0;
            bus.ack0    <= 1'b0;
            bus.ack1    <= 1'b0;
            bus.rdata0  <= '0;
            bus.rdata1  <= '0;
        end else begin
            bus.gb_we <= 1'b0;
            bus.gb_re <= 1'b0;
            bus.ack0  <= 1'b0;
            bus.ack1  <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_valid) begin
                        gnt         <= grant_idx;
                        last_grant  <= grant_idx;
                        cur_we      <= sel_we;
                        bus.gb_addr <= sel_addr;
                        bus.gb_dout <= sel_wdata;
                        bus.gb_we   <= sel_we;
                        bus.gb_re   <= ~sel_we;
                        state       <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (cur_we) begin
                        bus.ack0 <= ~gnt;
                        bus.ack1 <= gnt;
                        state    <= DONE;
                    end else begin
                        lat_cnt <= LAT_W'(RD_LAT - 1);
                        state   <= WAIT;
                    end
                end
                WAIT: begin
                    // Counter hits zero exactly when gb_din is due for this read.
                    if (lat_cnt == '0) begin
                        if (gnt) begin
                            bus.rdata1 <= bus.gb_din;
                            bus.ack1   <= 1'b1;
                        end else begin
                            bus.rdata0 <= bus.gb_din;
                            bus.ack0   <= 1'b1;
                        end
                        state <= DONE;
                    end else begin
                        lat_cnt <= lat_cnt - LAT_W'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gb_host_arb.sv
// Self-checking bench for gb_host_arb: directed vector table, hand-written corner sequences,
// then randomized traffic against a transaction-level reference model.
`timescale 1ns/1ps
module tb_gb_host_arb;

    localparam int AW     = 24;
    localparam int DW     = 32;
    localparam int RD_LAT = 3;
    localparam int NRND   = 2000;
    localparam int NARR   = NRND + 32;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    gb_host_arb_if #(.AW(AW), .DW(DW)) bus();

    gb_host_arb #(.AW(AW), .DW(DW), .RD_LAT(RD_LAT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        int            c;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] dout;
    } strobe_t;

    typedef struct {
        bit            idx;
        bit            we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] din;
        int            lat;
        logic [DW-1:0] rd0;
        logic [DW-1:0] rd1;
    } vec_t;

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;

    strobe_t st_q[$];
    int      ack_log[$];

    bit            rsp_en   = 1'b1;
    int            rsp_pend = 0;
    logic [DW-1:0] rsp_val  = '0;

    // reference model state for the random phase
    logic          exp_we[NARR];
    logic          exp_re[NARR];
    logic          exp_a0[NARR];
    logic          exp_a1[NARR];
    logic          upd_v0[NARR];
    logic          upd_v1[NARR];
    logic [DW-1:0] upd_d0[NARR];
    logic [DW-1:0] upd_d1[NARR];
    logic          din_v[NARR];
    logic [DW-1:0] din_at[NARR];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic drive_req(input bit idx, input bit req, input bit we,
                             input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
        if (idx) begin
            bus.req1 = req; bus.we1 = we; bus.addr1 = addr; bus.wdata1 = wdata;
        end else begin
            bus.req0 = req; bus.we0 = we; bus.addr0 = addr; bus.wdata0 = wdata;
        end
    endtask

    task automatic clear_logs();
        st_q.delete();
        ack_log.delete();
    endtask

    // One cycle: observe at the falling edge, log strobes/acks, then drive gb_din for the next edge.
    task automatic tick();
        @(negedge clk);
        cyc++;
        chk("we_re_exclusive", 128'(bus.gb_we & bus.gb_re), 128'd0);
        chk("ack_exclusive", 128'(bus.ack0 & bus.ack1), 128'd0);
        if (bus.gb_we || bus.gb_re)
            st_q.push_back('{c: cyc, we: bus.gb_we, addr: bus.gb_addr, dout: bus.gb_dout});
        if (bus.ack0) ack_log.push_back(0);
        if (bus.ack1) ack_log.push_back(1);
        if (rsp_en) begin
            if (rsp_pend > 0) begin
                rsp_pend--;
                bus.gb_din = (rsp_pend == 0) ? rsp_val : DW'($urandom());
            end else begin
                bus.gb_din = DW'($urandom());
            end
            if (bus.gb_re) rsp_pend = RD_LAT;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[6];
        int   lat;
        int   k0, k1, acks;
        logic [1:0]    in_req;
        logic          in_rst;
        logic          in_we[2];
        logic [AW-1:0] in_addr[2];
        logic [DW-1:0] in_wd[2];
        int            free_at;
        bit            lg;
        logic [AW-1:0] m_addr;
        logic [DW-1:0] m_dout, m_rd0, m_rd1;

        vecs[0] = '{idx: 0, we: 1, addr: 24'h000010, wdata: 32'hDEADBEEF, din: 32'h0,
                    lat: 2, rd0: 32'h0, rd1: 32'h0};
        vecs[1] = '{idx: 1, we: 0, addr: 24'h0000A4, wdata: 32'h0, din: 32'h12345678,
                    lat: 2 + RD_LAT, rd0: 32'h0, rd1: 32'h12345678};
        vecs[2] = '{idx: 0, we: 0, addr: 24'h000200, wdata: 32'h5555AAAA, din: 32'hCAFEF00D,
                    lat: 2 + RD_LAT, rd0: 32'hCAFEF00D, rd1: 32'h12345678};
        vecs[3] = '{idx: 1, we: 1, addr: 24'h000300, wdata: 32'h0BADC0DE, din: 32'h0,
                    lat: 2, rd0: 32'hCAFEF00D, rd1: 32'h12345678};
        vecs[4] = '{idx: 0, we: 1, addr: 24'hFFFFFF, wdata: 32'hFFFFFFFF, din: 32'h0,
                    lat: 2, rd0: 32'hCAFEF00D, rd1: 32'h12345678};
        vecs[5] = '{idx: 1, we: 0, addr: 24'hFFFFFF, wdata: 32'h0, din: 32'hA5A5A5A5,
                    lat: 2 + RD_LAT, rd0: 32'hCAFEF00D, rd1: 32'hA5A5A5A5};

        // Reset held with both requesters asking: outputs stay zero, requester 0 wins first.
        rst_n = 1'b0;
        bus.gb_din = '0;
        drive_req(0, 1, 1, 24'h000055, 32'h11111111);
        drive_req(1, 1, 1, 24'h000066, 32'h22222222);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("reset_outputs",
                {bus.ack0, bus.ack1, bus.gb_we, bus.gb_re, bus.gb_addr, bus.gb_dout,
                 bus.rdata0, bus.rdata1}, 128'd0);
        end
        clear_logs();
        rst_n = 1'b1;
        for (int n = 0; n < 40 && ack_log.size() < 2; n++) begin
            tick();
            if (bus.ack0) drive_req(0, 0, 0, '0, '0);
            if (bus.ack1) drive_req(1, 0, 0, '0, '0);
        end
        chk("reset_strobe_count", 128'(st_q.size()), 128'd2);
        if (st_q.size() >= 1) chk("reset_first_grant_addr", 128'(st_q[0].addr), 128'h000055);
        chk("reset_ack_count", 128'(ack_log.size()), 128'd2);
        if (ack_log.size() >= 1) chk("reset_first_ack", 128'(ack_log[0]), 128'd0);

        // Directed single transactions from the vector table.
        for (int v = 0; v < 6; v++) begin
            tick();
            clear_logs();
            rsp_val = vecs[v].din;
            drive_req(vecs[v].idx, 1, vecs[v].we, vecs[v].addr, vecs[v].wdata);
            lat = 0;
            for (int n = 1; n <= 40 && lat == 0; n++) begin
                tick();
                if (vecs[v].idx ? bus.ack1 : bus.ack0) lat = n;
            end
            drive_req(vecs[v].idx, 0, 0, '0, '0);
            chk($sformatf("vec%0d_latency", v), 128'(lat), 128'(vecs[v].lat));
            chk($sformatf("vec%0d_rdata0", v), 128'(bus.rdata0), 128'(vecs[v].rd0));
            chk($sformatf("vec%0d_rdata1", v), 128'(bus.rdata1), 128'(vecs[v].rd1));
            chk($sformatf("vec%0d_strobes", v), 128'(st_q.size()), 128'd1);
            if (st_q.size() >= 1) begin
                chk($sformatf("vec%0d_strobe_we", v), 128'(st_q[0].we), 128'(vecs[v].we));
                chk($sformatf("vec%0d_gb_addr", v), 128'(st_q[0].addr), 128'(vecs[v].addr));
                chk($sformatf("vec%0d_gb_dout", v), 128'(st_q[0].dout), 128'(vecs[v].wdata));
            end
            chk($sformatf("vec%0d_acks", v), 128'(ack_log.size()), 128'd1);
            if (ack_log.size() >= 1)
                chk($sformatf("vec%0d_ack_owner", v), 128'(ack_log[0]), 128'(vecs[v].idx));
        end

        // Continuous dual requests: grants must alternate starting with requester 0.
        tick();
        clear_logs();
        k0 = 0;
        k1 = 0;
        drive_req(0, 1, 1, 24'h000100, 32'h00000100);
        drive_req(1, 1, 1, 24'h000200, 32'h00000200);
        for (int n = 0; n < 80 && ack_log.size() < 6; n++) begin
            tick();
            if (bus.ack0) begin
                k0++;
                if (k0 < 3) drive_req(0, 1, 1, AW'(24'h000100 + k0), DW'(32'h100 + k0));
                else drive_req(0, 0, 0, '0, '0);
            end
            if (bus.ack1) begin
                k1++;
                if (k1 < 3) drive_req(1, 1, 1, AW'(24'h000200 + k1), DW'(32'h200 + k1));
                else drive_req(1, 0, 0, '0, '0);
            end
        end
        drive_req(0, 0, 0, '0, '0);
        drive_req(1, 0, 0, '0, '0);
        repeat (4) tick();
        chk("cont_strobes", 128'(st_q.size()), 128'd6);
        chk("cont_acks", 128'(ack_log.size()), 128'd6);
        for (int i = 0; i < 6; i++) begin
            if (i < st_q.size())
                chk($sformatf("cont_grant%0d", i), 128'(st_q[i].addr[9:8]), 128'((i % 2) + 1));
            if (i < ack_log.size())
                chk($sformatf("cont_ack%0d", i), 128'(ack_log[i]), 128'(i % 2));
        end

        // Back-to-back writes from requester 0 holding req through its ack.
        tick();
        clear_logs();
        acks = 0;
        drive_req(0, 1, 1, 24'h000400, 32'hB2B00001);
        for (int n = 0; n < 30 && acks < 2; n++) begin
            tick();
            if (bus.ack0) begin
                acks++;
                if (acks == 1) drive_req(0, 1, 1, 24'h000404, 32'hB2B00002);
                else drive_req(0, 0, 0, '0, '0);
            end
        end
        drive_req(0, 0, 0, '0, '0);
        repeat (4) tick();
        chk("b2b_strobes", 128'(st_q.size()), 128'd2);
        if (st_q.size() == 2) begin
            chk("b2b_spacing", 128'(st_q[1].c - st_q[0].c), 128'd3);
            chk("b2b_second_addr", 128'(st_q[1].addr), 128'h000404);
            chk("b2b_second_dout", 128'(st_q[1].dout), 128'hB2B00002);
        end
        chk("b2b_acks", 128'(ack_log.size()), 128'd2);
        chk("b2b_rdata1_kept", 128'(bus.rdata1), 128'hA5A5A5A5);

        // Reset while a read is waiting for its data: no ack, late data ignored, rdata cleared.
        tick();
        clear_logs();
        rsp_val = 32'h77777777;
        drive_req(1, 1, 0, 24'h000500, '0);
        tick();
        chk("rstmid_re_issued", 128'(bus.gb_re), 128'd1);
        tick();
        rst_n = 1'b0;
        drive_req(1, 0, 0, '0, '0);
        tick();
        rst_n = 1'b1;
        repeat (8) tick();
        chk("rstmid_no_ack", 128'(ack_log.size()), 128'd0);
        chk("rstmid_rdata1", 128'(bus.rdata1), 128'd0);
        chk("rstmid_rdata0", 128'(bus.rdata0), 128'd0);
        chk("rstmid_strobes", 128'(st_q.size()), 128'd1);

        // Randomized traffic against the transaction-level model.
        rsp_en = 1'b0;
        for (int c = 0; c < NARR; c++) begin
            exp_we[c] = 0; exp_re[c] = 0; exp_a0[c] = 0; exp_a1[c] = 0;
            upd_v0[c] = 0; upd_v1[c] = 0; upd_d0[c] = '0; upd_d1[c] = '0;
            din_v[c] = 0; din_at[c] = '0;
        end
        free_at = 0;
        lg = 1'b1;
        m_addr = '0; m_dout = '0; m_rd0 = '0; m_rd1 = '0;
        rst_n = 1'b0;
        bus.gb_din = DW'($urandom());
        clear_logs();
        for (int t = 1; t <= NRND; t++) begin
            in_rst = rst_n;
            in_req = {bus.req1, bus.req0};
            in_we[0] = bus.we0; in_addr[0] = bus.addr0; in_wd[0] = bus.wdata0;
            in_we[1] = bus.we1; in_addr[1] = bus.addr1; in_wd[1] = bus.wdata1;
            tick();
            if (!in_rst) begin
                for (int c = t; c < NARR; c++) begin
                    exp_we[c] = 0; exp_re[c] = 0; exp_a0[c] = 0; exp_a1[c] = 0;
                    upd_v0[c] = 0; upd_v1[c] = 0;
                end
                lg = 1'b1;
                free_at = t + 1;
                m_addr = '0; m_dout = '0; m_rd0 = '0; m_rd1 = '0;
            end else if (t >= free_at && in_req != 2'b00) begin
                int w, ack_edge;
                w = (in_req == 2'b11) ? (lg ? 0 : 1) : (in_req[1] ? 1 : 0);
                lg = w[0];
                m_addr = in_addr[w];
                m_dout = in_wd[w];
                exp_we[t] = in_we[w];
                exp_re[t] = ~in_we[w];
                ack_edge = in_we[w] ? t + 1 : t + 1 + RD_LAT;
                if (w == 0) exp_a0[ack_edge] = 1; else exp_a1[ack_edge] = 1;
                if (!in_we[w]) begin
                    din_v[ack_edge]  = 1;
                    din_at[ack_edge] = DW'($urandom());
                    if (w == 0) begin upd_v0[ack_edge] = 1; upd_d0[ack_edge] = din_at[ack_edge]; end
                    else begin upd_v1[ack_edge] = 1; upd_d1[ack_edge] = din_at[ack_edge]; end
                end
                free_at = ack_edge + 2;
            end
            if (upd_v0[t]) m_rd0 = upd_d0[t];
            if (upd_v1[t]) m_rd1 = upd_d1[t];

            chk("rnd_gb_we", 128'(bus.gb_we), 128'(exp_we[t]));
            chk("rnd_gb_re", 128'(bus.gb_re), 128'(exp_re[t]));
            chk("rnd_ack0", 128'(bus.ack0), 128'(exp_a0[t]));
            chk("rnd_ack1", 128'(bus.ack1), 128'(exp_a1[t]));
            chk("rnd_gb_addr", 128'(bus.gb_addr), 128'(m_addr));
            chk("rnd_gb_dout", 128'(bus.gb_dout), 128'(m_dout));
            chk("rnd_rdata0", 128'(bus.rdata0), 128'(m_rd0));
            chk("rnd_rdata1", 128'(bus.rdata1), 128'(m_rd1));

            rst_n = ($urandom_range(0, 199) == 0) ? 1'b0 : 1'b1;
            for (int i = 0; i < 2; i++) begin
                bit cur_req, acked;
                cur_req = (i == 0) ? bus.req0 : bus.req1;
                acked   = (i == 0) ? exp_a0[t] : exp_a1[t];
                if (cur_req && acked) begin
                    if ($urandom_range(0, 1) == 1)
                        drive_req(i[0], 1, 1'($urandom_range(0, 1)), AW'($urandom()), DW'($urandom()));
                    else
                        drive_req(i[0], 0, 0, '0, '0);
                end else if (!cur_req && $urandom_range(0, 3) == 0) begin
                    drive_req(i[0], 1, 1'($urandom_range(0, 1)), AW'($urandom()), DW'($urandom()));
                end
            end
            bus.gb_din = din_v[t + 1] ? din_at[t + 1] : DW'($urandom());
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/gb_host_arb.md
Name: gb_host_arb

Overview:
- Two-requester arbiter and sequencer that shares one ghostbus host port between two independent bus masters, e.g. a host bridge and a local register sequencer.
- It accepts one transaction at a time from either requester and drives single-cycle write or read strobes onto the ghostbus.
- For reads, it waits a fixed read latency, captures the read data, and returns an ack and data to the granted requester.
- It sits above the ghostbus tree (the `GHOSTBUS_MAGIC` fan-out) that feeds the interposer and leaf instances.

Parameters:
- AW, 24, address width; matches ghostbus AW.
- DW, 32, data width; matches ghostbus DW.
- RD_LAT, 1, cycles from the gb_re cycle to valid gb_din; legal range 1..15.

Ports:
- clk  input  1  sole clock; all logic on posedge.
- rst_n  input  1  synchronous active-low reset, sampled on posedge clk.
- req0  input  1  requester 0 transaction request; held high until ack0.
- we0  input  1  requester 0: 1 = write, 0 = read; stable while req0 high.
- addr0  input  AW  requester 0 address; stable while req0 high.
- wdata0  input  DW  requester 0 write data; stable while req0 high.
- ack0  output  1  one-cycle completion pulse to requester 0.
- rdata0  output  DW  read data to requester 0; valid when ack0 is high.
- req1, we1, addr1, wdata1, ack1, rdata1  same as above for requester 1.
- gb_addr  output  AW  ghostbus address.
- gb_dout  output  DW  ghostbus write data.
- gb_we  output  1  ghostbus write strobe; one cycle per write.
- gb_re  output  1  ghostbus read strobe; one cycle per read.
- gb_din  input  DW  ghostbus read data; valid RD_LAT cycles after the gb_re cycle.

Behaviour:
- Reset values (rst_n low at a posedge): all outputs 0, FSM in IDLE, lat_cnt 0, last_grant 1 so that req0 wins the first tie.
- Reset mid-transaction: the in-flight read or write is abandoned, no ack is issued, and a late gb_din is ignored.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - If any req is high at the posedge, select a winner and latch its we, addr and wdata into gb_addr and gb_dout. Go to ISSUE.
  - Tie (both req high): grant the requester that is not last_grant, then set last_grant to the winner.
  - Single req: grant it and update last_grant.
- ISSUE, exactly 1 cycle:
  - gb_we = latched we; gb_re = !latched we.
  - Write → DONE.
  - Read → WAIT with lat_cnt = RD_LAT-1.
- WAIT: decrement lat_cnt each cycle. At the posedge where lat_cnt == 0, capture gb_din into the granted requester's rdata and go to DONE. The WAIT state lasts RD_LAT cycles.
- DONE, 1 cycle: ackN = 1 for the granted requester only, then → IDLE.
  - req inputs are ignored while in DONE.
  - A requester keeping req high after seeing ack issues a new back-to-back transaction, which is considered in IDLE next cycle.
- Latency, with req sampled in IDLE at edge E0:
  - write ack is high in cycle E0+2;
  - read ack is high in cycle E0+2+RD_LAT.
- gb_addr and gb_dout hold their last values outside ISSUE; gb_we and gb_re are 0 outside ISSUE.
- rdataN holds its value until the next read completes for that requester.
- Writes never alter rdataN.
- gb_we and gb_re are never high simultaneously.
- At most one ack is high in any cycle.
- Fairness: under continuous dual requests, grants strictly alternate 0,1,0,1…

Decomposition:
- Package gb_arb_pkg contains:
  - state enum {IDLE, ISSUE, WAIT, DONE} (2-bit);
  - localparam LAT_W = 4;
  - function to check RD_LAT is in range (elaboration assertion).
- One natural sub-module: gb_rr_pick2, a combinational 2-way round-robin picker with inputs req0, req1, last_grant and outputs grant_valid, grant_idx.
- FSM, latches and the latency counter stay in gb_host_arb.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with req0=1 → all outputs 0, no gb_we or gb_re; after release, the first ISSUE is for requester 0.
- Single write: req0=1, we0=1, addr0=0x000010, wdata0=0xDEADBEEF → gb_we=1 for exactly one cycle with matching gb_addr and gb_dout; ack0 at E0+2; rdata0 unchanged.
- Single read with RD_LAT=3: req1=1, we1=0, addr1=0x0000A4; bench drives gb_din=0x12345678 exactly 3 cycles after gb_re → ack1 at E0+5 with rdata1=0x12345678; ack0 stays 0.
- Contention: req0 and req1 both held high for 6 transactions → grant order 0,1,0,1,0,1; no overlapping strobes; each ack matches its requester.
- Back-to-back: req0 held high through ack0 for 2 writes → second gb_we occurs 3 cycles after the first, with no duplicate ack.
- Reset mid-read: assert rst_n=0 during WAIT → no ack; gb_din arriving afterwards is ignored; rdata is cleared to 0.
